adc_spi_slave: RTL

ADC_SPI_SLAVE -- requirements
Module: adc_spi_slave

---
 rtl/adc_spi_if.sv | 23 ++
 rtl/adc_spi_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_if.sv
// ---------------------------------------------------------------------------
// adc_spi_if -- SPI bus between an external SPI master and adc_spi_slave.
//
// Signals:
//   SS_n  slave select, active-low (master -> slave)
//   SCLK  serial clock, idle high (master -> slave)
//   MOSI  command bit, valid at SCLK rise (master -> slave)
//   MISO  response bit, updated after SCLK fall (slave -> master)
//
// Handshake: a transaction is SS_n low for 16 SCLK rises. The master drives
// MOSI and samples MISO at each SCLK rise. The slave shifts MISO after each
// SCLK fall that follows at least one rise. SS_n going high closes the
// transaction; SS_n high before the 16th rise aborts it.
// ---------------------------------------------------------------------------
interface adc_spi_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_slave.sv
// ---------------------------------------------------------------------------
// adc_spi_slave -- SPI slave front end for an eight-channel ADC value store.
//
// A 16-bit command selects the channel returned by the *next* transaction;
// the current transaction returns {4'h0, val[chnl]} MSB first. Commands of the
// form {2'b00, ch[2:0], 11'd0} are legal; anything else raises cmd_err.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   spi        adc_spi_if.slave (SS_n, SCLK, MOSI in; MISO out)
//   ld         host write strobe for val[ld_chnl] <= ld_val
//   ld_chnl    host write channel (3 bits)
//   ld_val     host write value (12 bits)
//   xfer_done  one-clk pulse per completed 16-bit transaction
//   cmd_err    one-clk pulse, coincident with xfer_done, on an illegal command
//   chnl       channel pointer used for the next response
//   state_o    FSM state (0 IDLE, 1 SHIFT, 2 WAIT_SS) for observation
//
// Build option: define ADC_AUTO_INC_EN to add 12'h010 to the returned
// channel's value after every successful transaction (host ld wins).
// ---------------------------------------------------------------------------
module adc_spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  adc_spi_if.slave    spi,
  input  logic        ld,
  input  logic [2:0]  ld_chnl,
  input  logic [11:0] ld_val,
  output logic        xfer_done,
  output logic        cmd_err,
  output logic [2:0]  chnl,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_SS = 2'd2
  } state_t;

  state_t      state_q, state_d;

  // Synchronizers; the third stage of SCLK/SS_n is history for edge detect.
  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic        ss_s1_q, ss_s2_q, ss_s3_q;
  logic        mosi_s1_q, mosi_s2_q;

  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  chnl_q, chnl_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [11:0] val_q [8];

  logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic        cmd_legal;
  logic        load_tx;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;
  assign cmd_legal = (rx_q[15:14] == 2'b00) && (rx_q[10:0] == 11'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      ss_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi.SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= spi.SS_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      mosi_s1_q <= spi.MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT: begin
        if (ss_rise)                                state_d = IDLE;
        else if (sclk_rise && (cnt_q == 5'd15))     state_d = WAIT_SS;
      end
      WAIT_SS: if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath next values
  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    chnl_d  = chnl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_tx = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          load_tx = 1'b1;
          tx_d    = {4'h0, val_q[chnl_q]};
          rx_d    = 16'h0;
          cnt_d   = 5'd0;
        end
      end
      SHIFT: begin
        // An SS_n rise here is an abort: nothing is committed.
        if (!ss_rise) begin
          if (sclk_rise) begin
            rx_d  = {rx_q[14:0], mosi_s2_q};
            cnt_d = cnt_q + 5'd1;
          end
          // The fall before the first rise only sets up the master; bit 15
          // is already on MISO from the load.
          if (sclk_fall && (cnt_q != 5'd0)) tx_d = {tx_q[14:0], 1'b0};
        end
      end
      WAIT_SS: begin
        // Trailing falls keep shifting zeros so MISO settles at 0.
        if (sclk_fall) tx_d = {tx_q[14:0], 1'b0};
        if (ss_rise) begin
          done_d = 1'b1;
          if (cmd_legal) chnl_d = rx_q[13:11];
          else           err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= 16'h0;
      rx_q   <= 16'h0;
      cnt_q  <= 5'd0;
      chnl_q <= 3'h0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      chnl_q <= chnl_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

`ifdef ADC_AUTO_INC_EN
  // Channel whose value is being returned by the transaction in flight.
  logic [2:0] src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       src_q <= 3'h0;
    else if (load_tx) src_q <= chnl_q;
  end
`endif

  // Channel value store; a host ld is written last so it wins over the
  // auto-increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) val_q[i] <= {4'hC, 1'b0, 3'(i), 4'h0};
    end else begin
`ifdef ADC_AUTO_INC_EN
      if (done_q && !err_q) val_q[src_q] <= val_q[src_q] + 12'h010;
`endif
      if (ld) val_q[ld_chnl] <= ld_val;
    end
  end

  assign spi.MISO  = ((state_q != IDLE) && !ss_s2_q) ? tx_q[15] : 1'b0;
  assign xfer_done = done_q;
  assign cmd_err   = err_q;
  assign chnl      = chnl_q;
  assign state_o   = state_q;

`ifndef ADC_AUTO_INC_EN
  logic unused_load_tx;
  assign unused_load_tx = load_tx;
`endif

endmodule
